systolic_seq: RTL and testbench
===============================

SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001: Parameter N, default 4, array dimension (N x N PEs), power of two, 2..16.
REQ-002: Parameter KW, default 8, width of activation-vector count and indices.
REQ-003: clock  input  1  single clock for all state, rising edge.
REQ-004: resetb  input  1  asynchronous reset, active low.
REQ-005: start  input  1  run request, sampled only in IDLE.
REQ-006: abort  input  1  cancel run, sampled in every non-IDLE state.
REQ-007: cfg_k  input  KW  activation vectors per run, latched when start is accepted.
REQ-008: w_avail  input  1  weight source holds the next row.
REQ-009: a_avail  input  1  activation source holds the next vector.
REQ-010: w_load  output  1  load weight row w_row into the array this cycle.
REQ-011: w_row  output  log2(N)  weight row index.
REQ-012: acc_clr  output  1  clear PE accumulators.
REQ-013: array_en  output  1  advance array pipeline one step; low freezes it.
REQ-014: a_feed  output  1  inject activation vector a_idx this cycle.
REQ-015: a_idx  output  KW  index of vector being fed.
REQ-016: out_valid  output  1  result column out_idx present at array output.
REQ-017: out_idx  output  KW  index of the result.
REQ-018: busy, done, err  output  1 each  status; state  output  3  encoded state.

Function
REQ-019: The states SHALL be IDLE=0, LOAD_W=1, CLEAR=2, STREAM=3, DRAIN=4, DONE=5; state output = current encoding; busy = (state != IDLE).
REQ-020: IDLE: start=1, abort=0, cfg_k!=0 -> LOAD_W, latch K=cfg_k, clear err; cfg_k==0 -> DONE with err set.
REQ-021: LOAD_W: w_load = w_avail (combinational); each w_load increments w_row; w_load with w_row==N-1 -> CLEAR, w_row back to 0.
REQ-022: CLEAR: acc_clr=1 for exactly one cycle, ecnt and a_idx zeroed -> STREAM.
REQ-023: STREAM: a_feed = array_en = a_avail (combinational); each a_feed increments a_idx; a_feed with a_idx==K-1 -> DRAIN.
REQ-024: DRAIN: array_en=1 every cycle, a_feed=0.
REQ-025: Internal ecnt SHALL count array_en cycles from 0 at STREAM entry, width KW+log2(2N), never wrapping for K up to 2^KW-1.
REQ-026: With L=2N-1: out_valid = array_en AND L <= ecnt <= K+L-1; out_idx = ecnt-L.
REQ-027: DRAIN -> DONE on the array_en cycle with ecnt==K+L-1.
REQ-028: DONE: done=1 for exactly one cycle -> IDLE.
REQ-029: abort=1 in any non-IDLE state -> IDLE next edge; counters zeroed, err set, done not asserted; abort takes priority over every other transition.
REQ-030: start and abort both high in IDLE: remain IDLE, err unchanged.
REQ-031: start while busy SHALL be ignored, with no effect on the latched K.
REQ-032: w_load, acc_clr, a_feed, array_en, out_valid SHALL be 0 outside their stated states.
REQ-033: err is sticky until the next accepted start with cfg_k!=0.

Reset
REQ-034: resetb=0 SHALL immediately force state=IDLE, all counters, K, err and all outputs to 0, independent of clock.
REQ-035: Assertion mid-run discards the run; after release, the block accepts start on the first rising edge.

Verification
REQ-036: N=4, K=3, w_avail=a_avail=1, start at cycle 0 -> w_load cycles 1-4 (rows 0-3), acc_clr cycle 5, a_feed cycles 6-8 (a_idx 0,1,2), DRAIN cycles 9-15, out_valid cycles 13-15 (out_idx 0,1,2), done cycle 16, IDLE cycle 17.
REQ-037: Same run with a_avail=0 at cycles 7-8 and w_avail=0 at cycle 2 -> array_en low on exactly those STREAM cycles; all later events shift +3 cycles; done cycle 19.
REQ-038: start with cfg_k=0 -> no w_load, done=1 and err=1 at cycle 1; err stays 1 until start with cfg_k=1.
REQ-039: abort in DRAIN -> IDLE next cycle, busy=0, done never asserted, err=1; following run with K=1 completes and clears err.
REQ-040: resetb low mid-STREAM (K=5) -> all outputs 0 before next edge; after release, start with K=2 completes normally.
REQ-041: K=255 with constant avail -> 255 out_valid pulses, last out_idx=254, ecnt reaches 261 without wrap, done once.

Source files
------------

// File: rtl/systolic_seq_if.sv
// Array-side bus of the systolic sequencer.
//   w_avail / a_avail  : weight row / activation vector ready at the source
//   w_load, w_row      : load weight row w_row into the PE array
//   acc_clr            : clear PE accumulators
//   array_en           : advance the array pipeline one step
//   a_feed, a_idx      : inject activation vector a_idx
//   out_valid, out_idx : result column out_idx present at the array output
// master = sequencer, slave = array / data sources.
interface systolic_seq_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned KW = 8
);
   localparam int unsigned RW = $clog2(N);

   logic          w_avail;
   logic          a_avail;
   logic          w_load;
   logic [RW-1:0] w_row;
   logic          acc_clr;
   logic          array_en;
   logic          a_feed;
   logic [KW-1:0] a_idx;
   logic          out_valid;
   logic [KW-1:0] out_idx;

   modport master (
      input  w_avail, a_avail,
      output w_load, w_row, acc_clr, array_en, a_feed, a_idx, out_valid, out_idx
   );

   modport slave (
      output w_avail, a_avail,
      input  w_load, w_row, acc_clr, array_en, a_feed, a_idx, out_valid, out_idx
   );
endinterface

// File: rtl/systolic_seq.sv
// Run sequencer for an N x N weight-stationary systolic array.
// Each run loads N weight rows, clears the accumulators, streams K
// activation vectors and drains the array until all K results emerged.
// Ports:
//   clock, resetb : rising-edge clock, asynchronous active-low reset
//   start, cfg_k  : run request and vector count (taken in IDLE only)
//   abort         : cancel the current run (any non-IDLE state)
//   arr           : array-side bus (systolic_seq_if.master)
//   busy, done, err, state : status and encoded state
module systolic_seq #(
   parameter int unsigned N  = 4,
   parameter int unsigned KW = 8
) (
   input  logic          clock,
   input  logic          resetb,
   input  logic          start,
   input  logic          abort,
   input  logic [KW-1:0] cfg_k,
   systolic_seq_if.master arr,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [2:0]    state
);
   localparam int unsigned RW  = $clog2(N);
   localparam int unsigned ECW = KW + $clog2(2 * N);
   localparam logic [ECW-1:0] LAT = ECW'(2 * N - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD_W = 3'd1;
   localparam logic [2:0] S_CLEAR  = 3'd2;
   localparam logic [2:0] S_STREAM = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]     state_q;
   logic [KW-1:0]  k_q;
   logic [KW-1:0]  a_idx_q;
   logic [RW-1:0]  w_row_q;
   logic [ECW-1:0] ecnt_q;
   logic           err_q;

   logic           w_load;
   logic           a_feed;
   logic           array_en;
   logic           out_valid;
   logic [ECW-1:0] e_last;

   // ecnt value of the array_en cycle that carries the last result
   assign e_last = ECW'(k_q) + LAT - ECW'(1);

   always_comb begin
      w_load    = (state_q == S_LOAD_W) && arr.w_avail;
      a_feed    = (state_q == S_STREAM) && arr.a_avail;
      array_en  = a_feed || (state_q == S_DRAIN);
      out_valid = array_en && (ecnt_q >= LAT) && (ecnt_q <= e_last);
   end

   assign arr.w_load    = w_load;
   assign arr.w_row     = w_row_q;
   assign arr.acc_clr   = (state_q == S_CLEAR);
   assign arr.a_feed    = a_feed;
   assign arr.a_idx     = a_idx_q;
   assign arr.array_en  = array_en;
   assign arr.out_valid = out_valid;
   // gated so the index reads 0 in reset instead of ecnt-L wrapped
   assign arr.out_idx   = out_valid ? KW'(ecnt_q - LAT) : '0;

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign err   = err_q;
   assign state = state_q;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         a_idx_q <= '0;
         w_row_q <= '0;
         ecnt_q  <= '0;
         err_q   <= 1'b0;
      end else if (state_q != S_IDLE && abort) begin
         state_q <= S_IDLE;
         a_idx_q <= '0;
         w_row_q <= '0;
         ecnt_q  <= '0;
         err_q   <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  if (cfg_k != '0) begin
                     state_q <= S_LOAD_W;
                     k_q     <= cfg_k;
                     w_row_q <= '0;
                     err_q   <= 1'b0;
                  end else begin
                     state_q <= S_DONE;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_LOAD_W: begin
               if (w_load) begin
                  if (w_row_q == RW'(N - 1)) begin
                     state_q <= S_CLEAR;
                     w_row_q <= '0;
                  end else begin
                     w_row_q <= w_row_q + RW'(1);
                  end
               end
            end
            S_CLEAR: begin
               state_q <= S_STREAM;
               ecnt_q  <= '0;
               a_idx_q <= '0;
            end
            S_STREAM: begin
               if (a_feed) begin
                  ecnt_q  <= ecnt_q + ECW'(1);
                  a_idx_q <= a_idx_q + KW'(1);
                  if (a_idx_q == k_q - KW'(1)) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               ecnt_q <= ecnt_q + ECW'(1);
               if (ecnt_q == e_last) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_systolic_seq.sv
// Self-checking bench for systolic_seq: directed scenarios plus random runs,
// every cycle compared against a count-based reference model.
module tb_systolic_seq;
   localparam int unsigned N  = 4;
   localparam int unsigned KW = 8;
   localparam int unsigned L  = 2 * N - 1;

   logic          clock;
   logic          resetb;
   logic          start;
   logic          abort;
   logic [KW-1:0] cfg_k;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    state;

   systolic_seq_if #(.N(N), .KW(KW)) sif ();

   systolic_seq #(.N(N), .KW(KW)) dut (
      .clock  (clock),
      .resetb (resetb),
      .start  (start),
      .abort  (abort),
      .cfg_k  (cfg_k),
      .arr    (sif),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .state  (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   int done_cycle;
   int done_count;
   int ov_count;
   int last_oi;

   // reference model: a run is tracked only by how much work is complete
   bit          m_run, m_cleared, m_done, m_err;
   int unsigned m_k, m_rows, m_fed, m_steps;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_cleared = 0; m_done = 0; m_err = 0;
      m_k = 0; m_rows = 0; m_fed = 0; m_steps = 0;
   endtask

   function automatic int unsigned m_state();
      if (m_done)          return 5;
      if (!m_run)          return 0;
      if (m_rows < N)      return 1;
      if (!m_cleared)      return 2;
      if (m_fed < m_k)     return 3;
      return 4;
   endfunction

   task automatic compare();
      int unsigned st;
      bit e_wl, e_af, e_ae, e_ov;
      if (!resetb) model_reset();
      st   = m_state();
      e_wl = (st == 1) && sif.w_avail;
      e_af = (st == 3) && sif.a_avail;
      e_ae = e_af || (st == 4);
      e_ov = e_ae && (m_steps >= L) && (m_steps <= m_k + L - 1);
      check("state", state, st);
      check("busy", busy, st != 0);
      check("done", done, st == 5);
      check("err", err, m_err);
      check("w_load", sif.w_load, e_wl);
      if (e_wl) check("w_row", sif.w_row, m_rows);
      check("acc_clr", sif.acc_clr, st == 2);
      check("a_feed", sif.a_feed, e_af);
      if (e_af) check("a_idx", sif.a_idx, m_fed);
      check("array_en", sif.array_en, e_ae);
      check("out_valid", sif.out_valid, e_ov);
      if (e_ov) check("out_idx", sif.out_idx, m_steps - L);
   endtask

   task automatic model_update();
      int unsigned st;
      bit e_wl, e_af, e_ae;
      if (!resetb) begin
         model_reset();
         return;
      end
      st   = m_state();
      e_wl = (st == 1) && sif.w_avail;
      e_af = (st == 3) && sif.a_avail;
      e_ae = e_af || (st == 4);
      if (st == 0) begin
         if (start && !abort) begin
            if (cfg_k != 0) begin
               m_run = 1; m_k = cfg_k; m_err = 0;
               m_rows = 0; m_cleared = 0; m_fed = 0; m_steps = 0;
            end else begin
               m_done = 1; m_err = 1;
            end
         end
      end else if (abort) begin
         m_run = 0; m_done = 0; m_err = 1;
      end else if (st == 5) begin
         m_done = 0;
      end else begin
         if (e_wl) m_rows++;
         if (st == 2) m_cleared = 1;
         if (e_af) m_fed++;
         if (e_ae) m_steps++;
         if (st == 4 && m_steps == m_k + L) begin
            m_run = 0; m_done = 1;
         end
      end
   endtask

   // one clock cycle: check at the falling edge, advance model at the rising edge
   task automatic step();
      @(negedge clock);
      compare();
      if (done === 1'b1) begin
         done_count++;
         if (done_cycle < 0) done_cycle = cyc;
      end
      if (sif.out_valid === 1'b1) begin
         ov_count++;
         last_oi = sif.out_idx;
      end
      @(posedge clock);
      model_update();
      #1;
      cyc++;
   endtask

   task automatic check_all_zero();
      check("rst_state", state, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_w_load", sif.w_load, 0);
      check("rst_w_row", sif.w_row, 0);
      check("rst_acc_clr", sif.acc_clr, 0);
      check("rst_array_en", sif.array_en, 0);
      check("rst_a_feed", sif.a_feed, 0);
      check("rst_a_idx", sif.a_idx, 0);
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_out_idx", sif.out_idx, 0);
   endtask

   // mode 0: sources always ready; 1: fixed stall pattern; 2: random traffic
   task automatic run(input int unsigned k, input int mode, input int abort_at,
                      input int rst_at, input int limit);
      cyc = 0; done_cycle = -1; done_count = 0; ov_count = 0; last_oi = -1;
      start = 1'b1; cfg_k = KW'(k); abort = 1'b0;
      sif.w_avail = 1'b1; sif.a_avail = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (!m_run && !m_done) break;
         case (mode)
            1: begin
               sif.w_avail = (cyc != 2);
               sif.a_avail = !(cyc == 7 || cyc == 8);
            end
            2: begin
               sif.w_avail = ($urandom_range(0, 3) != 0);
               sif.a_avail = ($urandom_range(0, 3) != 0);
            end
            default: begin
               sif.w_avail = 1'b1;
               sif.a_avail = 1'b1;
            end
         endcase
         abort = (cyc == abort_at);
         if (mode == 2) begin
            start = ($urandom_range(0, 4) == 0);
            cfg_k = KW'($urandom);
            if ($urandom_range(0, 59) == 0) abort = 1'b1;
         end
         if (cyc == rst_at) begin
            #2 resetb = 1'b0;
            #1 check_all_zero();
         end
         step();
         resetb = 1'b1;
      end
      start = 1'b0; abort = 1'b0;
      check("run_terminated", m_run || m_done, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      resetb = 1'b0; start = 1'b0; abort = 1'b0; cfg_k = '0;
      sif.w_avail = 1'b0; sif.a_avail = 1'b0;
      model_reset();
      cyc = 0;
      #1 check_all_zero();
      repeat (2) step();
      resetb = 1'b1;
      step();

      // nominal K=3 run
      run(3, 0, -1, -1, 100);
      check("k3_done_cycle", done_cycle, 16);
      check("k3_done_count", done_count, 1);
      check("k3_out_count", ov_count, 3);
      check("k3_last_idx", last_oi, 2);

      // same run with three stall cycles
      run(3, 1, -1, -1, 100);
      check("stall_done_cycle", done_cycle, 19);
      check("stall_out_count", ov_count, 3);

      // zero-length run reports an error
      run(0, 0, -1, -1, 10);
      check("k0_done_cycle", done_cycle, 1);
      check("k0_out_count", ov_count, 0);
      repeat (2) step();
      start = 1'b1; abort = 1'b1; cfg_k = 8'd5;
      step();
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle_busy", busy, 0);
      check("start_abort_idle_err", err, 1);
      run(1, 0, -1, -1, 100);
      check("k1_done_cycle", done_cycle, 14);
      check("err_cleared", err, 0);

      // abort while draining
      run(3, 0, 10, -1, 100);
      check("abort_done_count", done_count, 0);
      check("abort_busy", busy, 0);
      check("abort_err", err, 1);
      run(1, 0, -1, -1, 100);
      check("after_abort_done", done_cycle, 14);
      check("after_abort_err", err, 0);

      // asynchronous reset mid-stream, then a clean run
      run(5, 0, -1, 8, 100);
      check("rst_no_done", done_count, 0);
      run(2, 0, -1, -1, 100);
      check("k2_done_cycle", done_cycle, 15);
      check("k2_out_count", ov_count, 2);

      // longest run: counter must not wrap
      run(255, 0, -1, -1, 400);
      check("k255_out_count", ov_count, 255);
      check("k255_last_idx", last_oi, 254);
      check("k255_done_count", done_count, 1);
      check("k255_done_cycle", done_cycle, 268);

      // random traffic, stray starts and aborts
      for (int r = 0; r < 40; r++) begin
         int unsigned k;
         k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
         run(k, 2, -1, -1, 40 * int'(k) + 200);
         repeat ($urandom_range(0, 2)) begin
            start = ($urandom_range(0, 1) == 0);
            abort = start;
            cfg_k = KW'($urandom);
            step();
         end
         start = 1'b0; abort = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
